// File: rtl/rs_ff_if.sv
// rtl/rs_ff_if.sv - set/clear request and state bundle for the rs_ff register
interface rs_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] invalid;

    modport master (
        output s,
        output r,
        input  q,
        input  qbar,
        input  invalid
    );

    modport slave (
        input  s,
        input  r,
        output q,
        output qbar,
        output invalid
    );
endinterface

// File: rtl/rs_ff.sv
// rtl/rs_ff.sv - per-bit clocked RS flip-flop with forbidden-combination flag
module rs_ff #(
    parameter int             WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic   clk,
    input  logic   rst_n,
    rs_ff_if.slave bus
);
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] invalid_d;
    logic [WIDTH-1:0] invalid_q;

    // Set wins only when clear is low; equal requests (both low or both high) hold.
    always_comb begin
        state_d   = (bus.s & ~bus.r) | (state_q & ~(bus.s ^ bus.r));
        invalid_d = bus.s & bus.r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_VALUE;
            invalid_q <= '0;
        end else begin
            state_q   <= state_d;
            invalid_q <= invalid_d;
        end
    end

    // qbar comes from the same register so the pair can never disagree.
    assign bus.q       = state_q;
    assign bus.qbar    = ~state_q;
    assign bus.invalid = invalid_q;
endmodule

// File: tb/tb_rs_ff.sv
// tb/tb_rs_ff.sv - randomized self-checking bench for rs_ff against a truth-table model
module tb_rs_ff;
    localparam logic [3:0] RV4 = 4'b1010;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;

    int checks = 0;
    int errors = 0;

    rs_ff_if #(.WIDTH(1)) bus1 ();
    rs_ff_if #(.WIDTH(4)) bus4 ();

    rs_ff #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    rs_ff #(.WIDTH(4), .RESET_VALUE(RV4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    always #2 clk = clk_en & ~clk;

    logic       m1_q, m1_inv;
    logic [3:0] m4_q, m4_inv;
    logic       d1_s, d1_r;
    logic [3:0] d4_s, d4_r;
    logic [2:0] got1, exp1;
    logic [11:0] got4, exp4;

    // Truth table of one RS bit: returns {next_q, next_invalid}.
    function automatic logic [1:0] rs_bit(input logic q, input logic s, input logic r);
        case ({s, r})
            2'b00:   return {q, 1'b0};
            2'b01:   return {1'b0, 1'b0};
            2'b10:   return {1'b1, 1'b0};
            default: return {q, 1'b1};
        endcase
    endfunction

    task automatic model_reset();
        m1_q = 1'b0; m1_inv = 1'b0;
        m4_q = RV4;  m4_inv = 4'b0;
    endtask

    task automatic model_edge();
        logic [1:0] n;
        n = rs_bit(m1_q, d1_s, d1_r);
        m1_q = n[1]; m1_inv = n[0];
        for (int i = 0; i < 4; i++) begin
            n = rs_bit(m4_q[i], d4_s[i], d4_r[i]);
            m4_q[i] = n[1]; m4_inv[i] = n[0];
        end
    endtask

    task automatic drive(input logic s1, input logic r1, input logic [3:0] s4, input logic [3:0] r4);
        d1_s = s1; d1_r = r1; d4_s = s4; d4_r = r4;
        bus1.s = s1; bus1.r = r1; bus4.s = s4; bus4.r = r4;
    endtask

    // Drives inputs, lets one rising edge happen, advances the model, returns 1 ns later.
    task automatic apply(input logic s1, input logic r1, input logic [3:0] s4, input logic [3:0] r4);
        drive(s1, r1, s4, r4);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic sample();
        got1 = {bus1.q, bus1.qbar, bus1.invalid};
        exp1 = {m1_q, ~m1_q, m1_inv};
        got4 = {bus4.q, bus4.qbar, bus4.invalid};
        exp4 = {m4_q, ~m4_q, m4_inv};
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 4'hF, 4'h0);
        #1 rst_n = 1'b0;
        model_reset();
        #3 sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL reset_low_w1 got q/qb/inv=%b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL reset_low_w4 got q/qb/inv=%b exp %b", got4, exp4); end
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        rst_n = 1'b1;
        #3 sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL reset_release_w1 got q/qb/inv=%b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL reset_release_w4 got q/qb/inv=%b exp %b", got4, exp4); end
        clk_en = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 25; i++) begin
            apply(1'b0, 1'b0, 4'h0, 4'h0);
            sample();
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL hold_w1 cyc %0d got %b exp %b", i, got1, exp1); end
            checks++;
            if (got4 !== exp4) begin errors++; $display("FAIL hold_w4 cyc %0d got %b exp %b", i, got4, exp4); end
        end
    endtask

    task automatic test_clear_then_set();
        for (int i = 0; i < 50; i++) begin
            if (i < 25) apply(1'b0, 1'b1, 4'h0, 4'hF);
            else        apply(1'b1, 1'b0, 4'hF, 4'h0);
            sample();
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL clr_set_w1 cyc %0d got %b exp %b", i, got1, exp1); end
            checks++;
            if (got4 !== exp4) begin errors++; $display("FAIL clr_set_w4 cyc %0d got %b exp %b", i, got4, exp4); end
        end
        checks++;
        if (bus1.q !== 1'b1) begin errors++; $display("FAIL set_final_q got %b exp 1", bus1.q); end
    endtask

    task automatic test_forbidden();
        apply(1'b1, 1'b0, 4'b0101, 4'b0000);
        for (int i = 0; i < 25; i++) begin
            apply(1'b1, 1'b1, 4'b0011, 4'b0110);
            sample();
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL forbid_w1 cyc %0d got %b exp %b", i, got1, exp1); end
            checks++;
            if (got4 !== exp4) begin errors++; $display("FAIL forbid_w4 cyc %0d got %b exp %b", i, got4, exp4); end
        end
        checks++;
        if (bus1.invalid !== 1'b1) begin errors++; $display("FAIL forbid_inv got %b exp 1", bus1.invalid); end
        apply(1'b0, 1'b0, 4'h0, 4'h0);
        sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL forbid_exit_w1 got %b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL forbid_exit_w4 got %b exp %b", got4, exp4); end
    endtask

    task automatic test_async_reset();
        apply(1'b1, 1'b0, 4'b0101, 4'b0000);
        apply(1'b1, 1'b1, 4'hF, 4'hF);
        // Pulse reset between edges while the forbidden condition is active.
        rst_n = 1'b0;
        model_reset();
        #1 sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL midreset_w1 got %b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL midreset_w4 got %b exp %b", got4, exp4); end
        // Reset held across an edge with active requests: inputs ignored.
        drive(1'b1, 1'b0, 4'b0101, 4'b1010);
        @(posedge clk);
        #1 sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL reset_ignore_w1 got %b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL reset_ignore_w4 got %b exp %b", got4, exp4); end
        rst_n = 1'b1;
        #1;
        apply(1'b1, 1'b0, 4'b0101, 4'b1010);
        sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL post_reset_w1 got %b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL post_reset_w4 got %b exp %b", got4, exp4); end
    endtask

    task automatic test_glitch();
        apply(1'b0, 1'b1, 4'b0000, 4'b1111);
        drive(1'b1, 1'b0, 4'b1111, 4'b0000);
        #1 drive(1'b0, 1'b0, 4'b0000, 4'b0000);
        @(posedge clk);
        model_edge();
        #1 sample();
        checks++;
        if (got1 !== exp1) begin errors++; $display("FAIL glitch_w1 got %b exp %b", got1, exp1); end
        checks++;
        if (got4 !== exp4) begin errors++; $display("FAIL glitch_w4 got %b exp %b", got4, exp4); end
    endtask

    task automatic test_random();
        logic [3:0] rs4, rr4;
        logic [1:0] sr1;
        for (int i = 0; i < 300; i++) begin
            rs4 = 4'($urandom);
            rr4 = 4'($urandom);
            sr1 = 2'($urandom);
            apply(sr1[1], sr1[0], rs4, rr4);
            sample();
            checks++;
            if (got1 !== exp1) begin errors++; $display("FAIL random_w1 cyc %0d got %b exp %b", i, got1, exp1); end
            checks++;
            if (got4 !== exp4) begin errors++; $display("FAIL random_w4 cyc %0d got %b exp %b", i, got4, exp4); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold();
        test_clear_then_set();
        test_forbidden();
        test_async_reset();
        test_glitch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rs_ff.md
RS_FF -- requirements
Module: rs_ff

Interface
REQ-001 Parameter: WIDTH, default 1, number of independent RS bits; every data port is WIDTH bits wide.
REQ-002 Parameter: RESET_VALUE, default 0, value loaded into q on reset, WIDTH bits; qbar loads its complement.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge except reset.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s  input  WIDTH  set request, per bit.
REQ-006 r  input  WIDTH  reset (clear) request, per bit.
REQ-007 q  output  WIDTH  registered flip-flop state.
REQ-008 qbar  output  WIDTH  complement of q, always equal to ~q.
REQ-009 invalid  output  WIDTH  registered flag; bit i is high for the cycle after s[i] and r[i] were both sampled high.

Function
REQ-010 Each bit i SHALL be evaluated independently at every rising edge of clk while rst_n is high.
REQ-011 s[i]=0, r[i]=0: q[i] SHALL hold its value; invalid[i] SHALL go 0.
REQ-012 s[i]=0, r[i]=1: q[i] SHALL become 0; invalid[i] SHALL go 0.
REQ-013 s[i]=1, r[i]=0: q[i] SHALL become 1; invalid[i] SHALL go 0.
REQ-014 s[i]=1, r[i]=1 (forbidden combination): q[i] SHALL hold its value and invalid[i] SHALL go 1.
REQ-015 Latency: q, qbar and invalid SHALL reflect the inputs sampled at edge N immediately after edge N; inputs have no combinational path to any output.
REQ-016 qbar SHALL be derived from the q register (not a separate register), so q and qbar never disagree, including during reset.
REQ-017 Input changes between clock edges SHALL have no effect on the outputs; the block is edge-triggered, not transparent.
REQ-018 invalid[i] SHALL stay high for consecutive cycles while s[i]=r[i]=1 persists and SHALL clear at the first edge that samples any other combination.

Reset
REQ-019 rst_n low SHALL immediately, without waiting for clk, force q=RESET_VALUE, qbar=~RESET_VALUE and invalid=0.
REQ-020 While rst_n is low, s and r SHALL be ignored and the outputs SHALL remain at their reset values.
REQ-021 After rst_n rises, the first rising clk edge SHALL evaluate s/r normally; no extra recovery cycles.
REQ-022 rst_n asserted mid-operation, including during a forbidden s=r=1 condition, SHALL override all pending updates and clear invalid.

Verification
REQ-023 rst_n=0 with clk stopped, then rst_n=1 -> q=0, qbar=1, invalid=0 with no clock edge required (WIDTH=1, RESET_VALUE=0).
REQ-024 s=0, r=0 for 100 ns (clk period 4 ns) after reset -> q stays 0, qbar stays 1 for every edge.
REQ-025 s=0, r=1 for 100 ns, then s=1, r=0 for 100 ns -> q=0 through the first window; q=1, qbar=0 from the first edge of the second window.
REQ-026 From q=1, s=1, r=1 for 100 ns -> q holds 1, invalid=1 from the first edge; then s=0, r=0 -> invalid=0 at the next edge and q still 1.
REQ-027 q=1, rst_n pulsed low between clock edges -> q=0, qbar=1 before the next edge; after release, s=1, r=0 sets q=1 at the first edge.
REQ-028 s toggled high and back low entirely between two rising edges -> q unchanged, confirming edge-triggered sampling.
